aligning_deserializer: RTL and testbench

- Multi-channel, word-aligning successor to the basic 1:S deserializer.
- Collects S beats of D bits per channel into one D*S word, with a qualified output valid.
- Frame boundary is shifted by beat-granular slip, either from an external request or from a built-in training FSM that hunts for a known pattern on channel 0.
- Sits between the high-speed capture front end and the slow-domain word consumer; all C channels share one frame boundary.

---
 rtl/aligning_deserializer.sv | 171 +++++++++++++++++
 tb/tb_aligning_deserializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aligning_deserializer.sv
// aligning_deserializer: C-channel 1:S deserializer with a shared, beat-granular
// frame boundary. The boundary moves one beat later per slip, requested either
// externally or by a training FSM that hunts for TRAIN_PATTERN on channel 0.
// Optional build macro DESER_LSB_FIRST_EN: beats enter at the LSB, so the first
// beat of a word lands in the MSB slice. Default build inserts at the MSB.
module aligning_deserializer #(
  parameter int              D             = 8,
  parameter int              S             = 4,
  parameter int              C             = 1,
  parameter logic [D*S-1:0]  TRAIN_PATTERN = 32'hA5C3_0FF0,
  parameter int              MATCH_COUNT   = 4,
  parameter int              SETTLE_WORDS  = 2
) (
  input  logic                   high_speed_clock,
  input  logic                   reset_n,
  input  logic [C*D-1:0]         data_in,
  input  logic                   data_in_valid,
  input  logic                   slip,
  input  logic                   train_en,
  output logic [C*D*S-1:0]       data_out,
  output logic                   data_out_valid,
  output logic                   aligned,
  output logic                   align_error,
  output logic [$clog2(S)-1:0]   slip_count
);

  localparam int CW = $clog2(S);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(S + 1);
  localparam int WW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     beat_count;
  logic              pending;
  logic [C*D*S-1:0]  shreg, shreg_next;
  logic [MW-1:0]     match_cnt, match_next;
  logic [TW-1:0]     tries, tries_next;
  logic [WW-1:0]     settle, settle_next;
  logic              aligned_next, align_error_next;
  logic              boundary, slip_req;

  // The beat completing a word always emits it; a pending slip waits for a
  // non-boundary beat so no word is ever cut short.
  assign boundary = (beat_count == CW'(S - 1));

  // External requests only count while training is not steering the boundary.
  assign slip_req = (slip && (state == ST_IDLE || state == ST_LOCKED)) ||
                    (state == ST_SLIP);

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_ch
`ifdef DESER_LSB_FIRST_EN
      assign shreg_next[gi*D*S +: D*S] = {shreg[gi*D*S +: D*(S-1)], data_in[gi*D +: D]};
`else
      assign shreg_next[gi*D*S +: D*S] = {data_in[gi*D +: D], shreg[gi*D*S+D +: D*(S-1)]};
`endif
    end
  endgenerate

  // Capture path: shift valid beats, emit words on the boundary, apply slips.
  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_count     <= '0;
      slip_count     <= '0;
      shreg          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      pending        <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      if (data_in_valid) begin
        shreg <= shreg_next;
        if (boundary) begin
          data_out       <= shreg_next;
          data_out_valid <= 1'b1;
          beat_count     <= '0;
        end else if (pending) begin
          slip_count <= (slip_count == CW'(S - 1)) ? '0 : slip_count + CW'(1);
        end else begin
          beat_count <= beat_count + CW'(1);
        end
      end
      if (pending) begin
        if (data_in_valid && !boundary) pending <= 1'b0;
      end else if (slip_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Training FSM state and bookkeeping registers.
  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      match_cnt   <= '0;
      tries       <= '0;
      settle      <= '0;
      aligned     <= 1'b0;
      align_error <= 1'b0;
    end else begin
      state       <= state_next;
      match_cnt   <= match_next;
      tries       <= tries_next;
      settle      <= settle_next;
      aligned     <= aligned_next;
      align_error <= align_error_next;
    end
  end

  // Training next-state: compare channel 0 on each emitted word, slip on miss.
  always_comb begin
    state_next       = state;
    match_next       = match_cnt;
    tries_next       = tries;
    settle_next      = settle;
    aligned_next     = aligned;
    align_error_next = align_error;
    if (!train_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next       = ST_CHECK;
          match_next       = '0;
          tries_next       = '0;
          aligned_next     = 1'b0;
          align_error_next = 1'b0;
        end
        ST_CHECK: begin
          if (data_out_valid) begin
            if (data_out[D*S-1:0] == TRAIN_PATTERN) begin
              match_next = match_cnt + MW'(1);
              if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                state_next   = ST_LOCKED;
                aligned_next = 1'b1;
              end
            end else begin
              match_next = '0;
              tries_next = tries + TW'(1);
              if (tries == TW'(S - 1)) begin
                state_next       = ST_FAIL;
                align_error_next = 1'b1;
              end else begin
                state_next = ST_SLIP;
              end
            end
          end
        end
        ST_SLIP: begin
          settle_next = '0;
          state_next  = (SETTLE_WORDS == 0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (data_out_valid) begin
            if (settle == WW'(SETTLE_WORDS - 1)) state_next = ST_CHECK;
            else settle_next = settle + WW'(1);
          end
        end
        ST_LOCKED: ;
        ST_FAIL:   ;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aligning_deserializer.sv
// Bench for aligning_deserializer (D=8, S=4, C=2): directed plan steps plus a
// randomized stream checked against a beat-history model of the framing rules.
module tb_aligning_deserializer;
  localparam int D  = 8;
  localparam int S  = 4;
  localparam int C  = 2;
  localparam int W  = C * D;
  localparam int OW = C * D * S;
  localparam int CW = $clog2(S);
  localparam logic [D*S-1:0] PAT = 32'hA5C3_0FF0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          slip = 1'b0;
  logic          train_en = 1'b0;
  logic [OW-1:0] data_out;
  logic          data_out_valid;
  logic          aligned;
  logic          align_error;
  logic [CW-1:0] slip_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aligning_deserializer #(.D(D), .S(S), .C(C)) dut (
    .high_speed_clock(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .slip(slip),
    .train_en(train_en),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .aligned(aligned),
    .align_error(align_error),
    .slip_count(slip_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: keeps the last S accepted beats; a word completes after
  // every S non-held beats, and a pending slip turns the next non-final beat
  // into a held one.
  logic [W-1:0]  hist[$];
  int            m_n, m_h;
  bit            m_pend, m_dov;
  logic [OW-1:0] m_out;

  function automatic void model_reset();
    hist.delete();
    m_n = 0; m_h = 0; m_pend = 0; m_dov = 0; m_out = '0;
  endfunction

  function automatic logic [OW-1:0] assemble();
    logic [OW-1:0] w;
    logic [W-1:0]  b;
    w = '0;
    for (int k = 0; k < S; k++) begin
      b = hist[k];
      for (int c = 0; c < C; c++) begin
`ifdef DESER_LSB_FIRST_EN
        w[c*D*S + (S-1-k)*D +: D] = b[c*D +: D];
`else
        w[c*D*S + k*D +: D] = b[c*D +: D];
`endif
      end
    end
    return w;
  endfunction

  function automatic void model_step(input logic [W-1:0] din, input bit v, input bit slp);
    bit last_of_word, hold;
    m_dov = 0;
    hold  = 0;
    if (v) begin
      last_of_word = ((m_n - m_h) % S) == S - 1;
      hold = m_pend && !last_of_word;
      hist.push_back(din);
      if (hist.size() > S) void'(hist.pop_front());
      m_n++;
      if (hold) m_h++;
      else if (((m_n - m_h) % S) == 0) begin
        m_dov = 1;
        m_out = assemble();
      end
    end
    if (m_pend) m_pend = !hold;
    else m_pend = slp;
  endfunction

  task automatic cycle(input logic [W-1:0] din, input bit v, input bit slp, input bit ten, input bit chk);
    data_in = din; data_in_valid = v; slip = slp; train_en = ten;
    @(posedge clk);
    if (chk) model_step(din, v, slp);
    @(negedge clk);
    if (chk) begin
      check("dov", data_out_valid, m_dov);
      check("data_out", data_out, m_out);
      check("slip_count", slip_count, m_h % S);
    end
  endtask

  task automatic do_reset();
    data_in = '0; data_in_valid = 0; slip = 0; train_en = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  function automatic logic [W-1:0] pair(input logic [7:0] b);
    return {8'h10 + b, b};
  endfunction

  logic [7:0] pb[4];
  int         cnt, idx, ti;
  logic [7:0] b0;

  initial begin
`ifdef DESER_LSB_FIRST_EN
    pb = '{8'hA5, 8'hC3, 8'h0F, 8'hF0};
`else
    pb = '{8'hF0, 8'h0F, 8'hC3, 8'hA5};
`endif
    // Reset state
    do_reset();
    check("rst_data_out", data_out, 0);
    check("rst_dov", data_out_valid, 0);
    check("rst_aligned", aligned, 0);
    check("rst_align_error", align_error, 0);
    check("rst_slip_count", slip_count, 0);

    // Continuous stream: one word every 4 beats
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(pair(8'((i % 4) + 1)), 1, 0, 0, 1);
      if (data_out_valid) cnt++;
    end
    check("plan_word", data_out, 64'h14131211_04030201);
    check("plan_pulses", cnt, 3);

    // Three idle cycles mid-word delay the pulse by three cycles
    do_reset();
    idx = -1;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i <= 4) cycle(16'hDEAD, 0, 0, 0, 1);
      else cycle(pair(8'(i < 2 ? i + 1 : i - 2)), 1, 0, 0, 1);
      if (data_out_valid && idx < 0) idx = i;
    end
    check("gap_word", data_out, 64'h14131211_04030201);
    check("gap_pulse_cycle", idx, 6);

    // One slip before the stream: boundary moves one beat later
    do_reset();
    cycle('0, 0, 1, 0, 1);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(pair(8'((i % 8) + 1)), 1, 0, 0, 1);
      if (data_out_valid) cnt++;
    end
    check("slip_count_one", slip_count, 1);
    check("slip_word", data_out, 64'h15141312_05040302);
    check("slip_pulses", cnt, 3);

    // Asynchronous reset mid-word clears outputs immediately
    do_reset();
    cycle('0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cycle(pair(8'(i + 1)), 1, 0, 0, 1);
    #2 reset_n = 0;
    #1;
    check("async_data_out", data_out, 0);
    check("async_dov", data_out_valid, 0);
    check("async_slip_count", slip_count, 0);
    #3 reset_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) cycle({8'hB1 + 8'(i), 8'hA1 + 8'(i)}, 1, 0, 0, 1);
    check("post_reset_word", data_out, 64'hB4B3B2B1_A4A3A2A1);

    // Randomized stream with sporadic valid gaps and slips
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(W'($urandom), $urandom_range(0, 3) != 0,
            !m_pend && ($urandom_range(0, 9) == 0), 0, 1);
    end

    // Training on a pattern stream two beats off phase
    do_reset();
    ti = 0;
    for (int i = 0; i < 300 && !aligned; i++) begin
      b0 = pb[(ti + 2) % 4];
      cycle({~b0, b0}, 1, 0, 1, 0);
      ti++;
    end
    check("train_aligned", aligned, 1);
    check("train_slips", slip_count, 2);
    check("train_no_error", align_error, 0);
    for (int i = 0; i < 8; i++) begin
      b0 = pb[(ti + 2) % 4]; cycle({~b0, b0}, 1, 0, 1, 0); ti++;
    end
    check("train_ch0_word", data_out[D*S-1:0], PAT);
    b0 = pb[(ti + 2) % 4]; cycle({~b0, b0}, 1, 1, 1, 0); ti++;
    for (int i = 0; i < 8; i++) begin
      b0 = pb[(ti + 2) % 4]; cycle({~b0, b0}, 1, 0, 1, 0); ti++;
    end
    check("locked_ext_slip", slip_count, 3);
    check("locked_holds", aligned, 1);
    for (int i = 0; i < 2; i++) cycle('0, 1, 0, 0, 0);
    check("idle_keeps_aligned", aligned, 1);
    cycle('0, 1, 0, 1, 0);
    check("restart_clears_aligned", aligned, 0);

    // Training on a constant stream exhausts all offsets
    do_reset();
    for (int i = 0; i < 400 && !align_error; i++) cycle('0, 1, 0, 1, 0);
    check("fail_error", align_error, 1);
    check("fail_not_aligned", aligned, 0);
    check("fail_slips", slip_count, 3);
    cycle('0, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle('0, 1, 0, 1, 0);
    check("fail_ignores_slip", slip_count, 3);
    for (int i = 0; i < 3; i++) cycle('0, 1, 0, 0, 0);
    check("idle_keeps_error", align_error, 1);
    cycle('0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle('0, 1, 0, 0, 0);
    check("idle_slip_wraps", slip_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
